conv3x3_core: RTL and testbench
===============================

Name: conv3x3_core

Overview:
- Downstream consumer of the 3x3 window line-buffer stage.
- Takes one 3x3 window of 8-bit pixels per enabled cycle and applies a programmable signed 3x3 kernel.
- Result is shifted right, clamped to 8 bits and emitted with a valid strobe.
- Counts output pixels per image row and pulses row_done_o for the controller and 7-segment logic.

Parameters:
- MAX_IMG_COLS, 540, valid outputs per row before row_done_o
- CNT_IMG_COLS, 10, width of the output column counter
- COEF_W, 8, signed coefficient width
- LATENCY, 3, pipeline depth; fixed, documentation only

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- core_en_i  in  1  window valid; window sampled this cycle
- data_0_0_i .. data_2_2_i  in  8 each  window pixels, unsigned, row_col order
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  4  0..8 = coefficient k[r*3+c]; 9 = shift; 10..15 reserved
- cfg_data_i  in  8  coefficient (signed COEF_W) or shift in bits [3:0]
- pix_o  out  8  filtered pixel
- pix_valid_o  out  1  pix_o valid this cycle
- row_done_o  out  1  one-cycle pulse with the MAX_IMG_COLS-th valid output
- cnt_out_col_o  out  CNT_IMG_COLS  debug: current output column count

Behaviour:
- Reset is synchronous, active-low on rst_n; clock is clk.
- Reset values:
  - pix_o=0, pix_valid_o=0, row_done_o=0, counter=0, all stage valid bits=0.
  - Kernel = identity (k[4]=1, others 0); shift=0.
- Config:
  - A write with cfg_addr_i 0..9 updates the register at the clock edge.
  - A window sampled in the same cycle as a write uses the old value; the new value applies from the next cycle's window.
  - Addresses 10..15 are ignored.
- Stage 1 (edge 1):
  - Each pixel is zero-extended to 9-bit signed, then multiplied by its coefficient, giving 17-bit signed products.
  - Captures the current shift value; v1 <= core_en_i.
- Stage 2 (edge 2): three row sums, each 19-bit signed; v2 <= v1.
- Stage 3 (edge 3):
  - Total = sum of the row sums, 21-bit signed, then arithmetic right shift by the captured shift.
  - Clamp: <0 -> 0, >255 -> 255.
  - pix_o <= result; pix_valid_o <= v2.
- Latency is exactly 3 cycles from core_en_i high to pix_valid_o high. Throughput is 1 window per cycle.
- Bubbles (core_en_i low) propagate as pix_valid_o low. pix_o holds its last value when not valid.
- Column counter:
  - Increments on each pix_valid_o.
  - When it equals MAX_IMG_COLS-1 and an output is valid: row_done_o=1 in that same cycle, and the counter wraps to 0 at the next edge.
  - row_done_o is combinational from counter==MAX_IMG_COLS-1 && pix_valid_o.
- Reset mid-stream clears all valid bits and the counter; in-flight windows are discarded. Coefficient and shift registers return to identity/0.

Optional Feature:
- Macro CONV_ABS_EN.
- Defined: negative totals are replaced by their magnitude before the shift, then clamped to 255. Intended for edge-magnitude kernels.
- Undefined: negatives clamp to 0 as above.

Decomposition:
- Package conv_pkg holds:
  - PIX_W=8, COEF_W, SUM_W=21.
  - cfg address constants CFG_K0..CFG_K8, CFG_SHIFT.
  - Identity kernel reset constant.
  - coef_t signed typedef.
- One sub-module, conv_clamp: combinational shift, optional absolute value, and saturate from SUM_W to 8 bits. Instanced in stage 3.

Test Plan:
- Identity after reset: window all 0x10, centre 0x5A, core_en_i 1 cycle -> pix_o=0x5A with pix_valid_o exactly 3 cycles later, 1 cycle wide.
- Box blur: k[0..8]=1, shift=3, all pixels 16 -> pix_o=18 (144>>3). All pixels 255 -> 2295>>3=286 -> pix_o=255.
- Sobel Gx:
  - Setup: k={-1,0,1,-2,0,2,-1,0,1}.
  - Left column 0, right column 255 -> 1020 -> pix_o=255.
  - Mirrored window -> -1020 -> pix_o=0; pix_o=255 with CONV_ABS_EN.
- Config timing: stream 4 back-to-back identity windows; write k[4]=2 in the cycle window 2 is sampled -> output 2 unscaled, outputs 3 and 4 doubled, centre 100 -> 200.
- Row done: 540 valid windows with random core_en_i gaps -> row_done_o high only with the 540th pix_valid_o; cnt_out_col_o=0 after; the 541st output does not pulse.
- Reset mid-stream: deassert rst_n for 1 cycle with 2 windows in flight -> no pix_valid_o afterwards, counter=0, kernel back to identity.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, config address map and reset kernel for the 3x3 convolution core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

   localparam int PIX_W  = 8;
   localparam int COEF_W = 8;
   localparam int SUM_W  = 21;

   // Config address map: kernel taps in row-major order, then the shift.
   localparam logic [3:0] CFG_K0    = 4'd0;
   localparam logic [3:0] CFG_K1    = 4'd1;
   localparam logic [3:0] CFG_K2    = 4'd2;
   localparam logic [3:0] CFG_K3    = 4'd3;
   localparam logic [3:0] CFG_K4    = 4'd4;
   localparam logic [3:0] CFG_K5    = 4'd5;
   localparam logic [3:0] CFG_K6    = 4'd6;
   localparam logic [3:0] CFG_K7    = 4'd7;
   localparam logic [3:0] CFG_K8    = 4'd8;
   localparam logic [3:0] CFG_SHIFT = 4'd9;

   typedef logic signed [COEF_W-1:0] coef_t;

   // Identity kernel: only the centre tap passes through.
   localparam coef_t K_IDENTITY [9] = '{8'sd0, 8'sd0, 8'sd0,
                                        8'sd0, 8'sd1, 8'sd0,
                                        8'sd0, 8'sd0, 8'sd0};

endpackage

// File: rtl/conv_clamp.sv
// Shift a signed convolution total right and saturate it to an 8-bit pixel.
// Latency: combinational.
// Backpressure: none.
// Ports: sum_i (signed total), shift_i (arithmetic right shift), pix_o (clamped pixel).
// Build option: CONV_ABS_EN takes the magnitude of negative totals before the shift.
module conv_clamp
   import conv_pkg::*;
#(
   parameter int IN_W = SUM_W
) (
   input  logic signed [IN_W-1:0]  sum_i,
   input  logic        [3:0]       shift_i,
   output logic        [PIX_W-1:0] pix_o
);

   localparam logic signed [IN_W-1:0] PIX_MAX = IN_W'(255);

   logic signed [IN_W-1:0] mag;
   logic signed [IN_W-1:0] shifted;

   always_comb begin
`ifdef CONV_ABS_EN
      // Edge-magnitude kernels: sign is irrelevant, keep the strength.
      mag = sum_i[IN_W-1] ? -sum_i : sum_i;
`else
      mag = sum_i;
`endif
      shifted = mag >>> shift_i;
      if (shifted[IN_W-1]) begin
         pix_o = '0;
      end else if (shifted > PIX_MAX) begin
         pix_o = '1;
      end else begin
         pix_o = shifted[PIX_W-1:0];
      end
   end

endmodule

// File: rtl/conv3x3_core.sv
// Programmable signed 3x3 convolution of a pixel window, shifted and clamped to 8 bits.
// Latency: 3 cycles from core_en_i to pix_valid_o, one window per cycle.
// Backpressure: none; core_en_i low inserts a bubble that emerges as pix_valid_o low.
// Ports: clk/rst_n (sync active-low), core_en_i + data_r_c_i window in, cfg_we/addr/data
//        kernel+shift writes, pix_o/pix_valid_o result, row_done_o/cnt_out_col_o row tracking.
// Build option: CONV_ABS_EN (see conv_clamp).
module conv3x3_core #(
   parameter int MAX_IMG_COLS = 540,
   parameter int CNT_IMG_COLS = 10,
   parameter int COEF_W       = conv_pkg::COEF_W,
   parameter int LATENCY      = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    core_en_i,
   input  logic [7:0]              data_0_0_i,
   input  logic [7:0]              data_0_1_i,
   input  logic [7:0]              data_0_2_i,
   input  logic [7:0]              data_1_0_i,
   input  logic [7:0]              data_1_1_i,
   input  logic [7:0]              data_1_2_i,
   input  logic [7:0]              data_2_0_i,
   input  logic [7:0]              data_2_1_i,
   input  logic [7:0]              data_2_2_i,
   input  logic                    cfg_we_i,
   input  logic [3:0]              cfg_addr_i,
   input  logic [7:0]              cfg_data_i,
   output logic [7:0]              pix_o,
   output logic                    pix_valid_o,
   output logic                    row_done_o,
   output logic [CNT_IMG_COLS-1:0] cnt_out_col_o
);

   import conv_pkg::*;

   localparam int PROD_W = PIX_W + 1 + COEF_W;  // 9-bit signed pixel x coefficient
   localparam int RSUM_W = PROD_W + 2;          // three products per row
   localparam int TOT_W  = RSUM_W + 2;          // three rows
   localparam logic [CNT_IMG_COLS-1:0] LAST_COL = CNT_IMG_COLS'(MAX_IMG_COLS - 1);

   logic        [PIX_W-1:0]        pix_in [9];
   logic signed [COEF_W-1:0]       k_q [9];
   logic signed [COEF_W-1:0]       k_d [9];
   logic        [3:0]              shift_q, shift_d;
   logic signed [PROD_W-1:0]       prod_q [9];
   logic signed [PROD_W-1:0]       prod_d [9];
   logic signed [RSUM_W-1:0]       rsum_q [3];
   logic signed [RSUM_W-1:0]       rsum_d [3];
   logic        [3:0]              shift1_q, shift2_q;
   // Valid shift register; the datapath has exactly three register stages,
   // so LATENCY must stay at 3 for data and valid to line up.
   logic        [LATENCY-1:0]      vld_q;
   logic signed [TOT_W-1:0]        total;
   logic        [PIX_W-1:0]        clamp_pix;
   logic        [PIX_W-1:0]        pix_q, pix_d;
   logic        [CNT_IMG_COLS-1:0] cnt_q, cnt_d;

   always_comb begin
      pix_in[0] = data_0_0_i;  pix_in[1] = data_0_1_i;  pix_in[2] = data_0_2_i;
      pix_in[3] = data_1_0_i;  pix_in[4] = data_1_1_i;  pix_in[5] = data_1_2_i;
      pix_in[6] = data_2_0_i;  pix_in[7] = data_2_1_i;  pix_in[8] = data_2_2_i;
   end

   // Config writes land at the edge; the window sampled at that same edge
   // still multiplies by k_q, so the new value applies from the next window.
   always_comb begin
      k_d     = k_q;
      shift_d = shift_q;
      if (cfg_we_i) begin
         case (cfg_addr_i)
            CFG_K0:    k_d[0]  = cfg_data_i[COEF_W-1:0];
            CFG_K1:    k_d[1]  = cfg_data_i[COEF_W-1:0];
            CFG_K2:    k_d[2]  = cfg_data_i[COEF_W-1:0];
            CFG_K3:    k_d[3]  = cfg_data_i[COEF_W-1:0];
            CFG_K4:    k_d[4]  = cfg_data_i[COEF_W-1:0];
            CFG_K5:    k_d[5]  = cfg_data_i[COEF_W-1:0];
            CFG_K6:    k_d[6]  = cfg_data_i[COEF_W-1:0];
            CFG_K7:    k_d[7]  = cfg_data_i[COEF_W-1:0];
            CFG_K8:    k_d[8]  = cfg_data_i[COEF_W-1:0];
            CFG_SHIFT: shift_d = cfg_data_i[3:0];
            default:   ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 9; i++) begin
         prod_d[i] = PROD_W'($signed({1'b0, pix_in[i]})) * PROD_W'(k_q[i]);
      end
      for (int r = 0; r < 3; r++) begin
         rsum_d[r] = RSUM_W'(prod_q[3*r]) + RSUM_W'(prod_q[3*r+1]) + RSUM_W'(prod_q[3*r+2]);
      end
      total = TOT_W'(rsum_q[0]) + TOT_W'(rsum_q[1]) + TOT_W'(rsum_q[2]);
   end

   conv_clamp #(.IN_W(TOT_W)) u_clamp (
      .sum_i   (total),
      .shift_i (shift2_q),
      .pix_o   (clamp_pix)
   );

   assign pix_d      = vld_q[LATENCY-2] ? clamp_pix : pix_q;
   assign row_done_o = vld_q[LATENCY-1] && (cnt_q == LAST_COL);

   always_comb begin
      cnt_d = cnt_q;
      if (vld_q[LATENCY-1]) begin
         cnt_d = row_done_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) begin
            k_q[i]    <= COEF_W'(K_IDENTITY[i]);
            prod_q[i] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            rsum_q[r] <= '0;
         end
         shift_q  <= '0;
         shift1_q <= '0;
         shift2_q <= '0;
         vld_q    <= '0;
         pix_q    <= '0;
         cnt_q    <= '0;
      end else begin
         k_q      <= k_d;
         shift_q  <= shift_d;
         prod_q   <= prod_d;
         shift1_q <= shift_q;
         rsum_q   <= rsum_d;
         shift2_q <= shift1_q;
         vld_q    <= {vld_q[LATENCY-2:0], core_en_i};
         pix_q    <= pix_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pix_o         = pix_q;
   assign pix_valid_o   = vld_q[LATENCY-1];
   assign cnt_out_col_o = cnt_q;

endmodule

// File: tb/tb_conv3x3_core.sv
// Self-checking bench for conv3x3_core: directed scenarios plus randomized row traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv3x3_core;

   localparam int MAX_COLS = 540;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              core_en = 1'b0;
   logic [8:0][7:0]   win = '0;
   logic              cfg_we = 1'b0;
   logic [3:0]        cfg_addr = '0;
   logic [7:0]        cfg_data = '0;
   logic [7:0]        pix;
   logic              pix_valid;
   logic              row_done;
   logic [9:0]        cnt_col;

   always #5 clk = ~clk;

   conv3x3_core dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .core_en_i     (core_en),
      .data_0_0_i    (win[0]),
      .data_0_1_i    (win[1]),
      .data_0_2_i    (win[2]),
      .data_1_0_i    (win[3]),
      .data_1_1_i    (win[4]),
      .data_1_2_i    (win[5]),
      .data_2_0_i    (win[6]),
      .data_2_1_i    (win[7]),
      .data_2_2_i    (win[8]),
      .cfg_we_i      (cfg_we),
      .cfg_addr_i    (cfg_addr),
      .cfg_data_i    (cfg_data),
      .pix_o         (pix),
      .pix_valid_o   (pix_valid),
      .row_done_o    (row_done),
      .cnt_out_col_o (cnt_col)
   );

   // Reference model state: kernel, shift, expected outputs keyed by edge number.
   int m_k [9];
   int m_shift;
   int m_cnt;
   int m_last;
   int ecnt;
   bit exp_v [int];
   int exp_p [int];

   // Observed outputs, used by the directed scenarios.
   int out_q [$];
   int out_cnt;
   int rd_pulses;
   int rd_at;

   int n_checks = 0;
   int n_errors = 0;

   int sobel [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   function automatic int model_pix(input logic [8:0][7:0] w);
      int s = 0;
      for (int i = 0; i < 9; i++) s += m_k[i] * int'(w[i]);
`ifdef CONV_ABS_EN
      if (s < 0) s = -s;
`endif
      s = s >>> m_shift;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) m_k[i] = (i == 4) ? 1 : 0;
      m_shift = 0;
      m_cnt   = 0;
      m_last  = 0;
      exp_v.delete();
      exp_p.delete();
   endtask

   // One clock: drive inputs, update the model at the edge, check at the falling edge.
   task automatic step(input logic en, input logic [8:0][7:0] w, input logic we,
                       input logic [3:0] a, input logic [7:0] d, input logic rst_v);
      bit ev;
      core_en  = en;
      win      = w;
      cfg_we   = we;
      cfg_addr = a;
      cfg_data = d;
      rst_n    = rst_v;
      @(posedge clk);
      ecnt++;
      if (!rst_v) begin
         model_reset();
      end else begin
         if (en) begin
            exp_v[ecnt + 2] = 1'b1;
            exp_p[ecnt + 2] = model_pix(w);
         end
         if (we && a < 9) m_k[a] = int'($signed(d));
         else if (we && a == 9) m_shift = int'(d[3:0]);
      end
      @(negedge clk);
      ev = exp_v.exists(ecnt);
      if (ev) m_last = exp_p[ecnt];
      check_val("pix_valid", pix_valid, ev);
      check_val("pix", pix, m_last);
      check_val("row_done", row_done, ev && (m_cnt == MAX_COLS - 1));
      check_val("cnt_col", cnt_col, m_cnt);
      if (ev) m_cnt = (m_cnt == MAX_COLS - 1) ? 0 : m_cnt + 1;
      if (pix_valid === 1'b1) begin
         out_q.push_back(int'(pix));
         out_cnt++;
         if (row_done === 1'b1) begin
            rd_pulses++;
            rd_at = out_cnt;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, 8'd0, 1'b1);
   endtask

   task automatic cfg(input logic [3:0] a, input logic [7:0] d);
      step(1'b0, '0, 1'b1, a, d, 1'b1);
   endtask

   function automatic logic [8:0][7:0] rand_win();
      logic [8:0][7:0] w;
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
      return w;
   endfunction

   initial begin
      logic [8:0][7:0] w;
      int sent;
      int iters;
      logic en;

      ecnt = 0;
      out_cnt = 0;
      rd_pulses = 0;
      rd_at = 0;
      model_reset();

      // Reset, then idle: everything reads zero.
      step(1'b0, '0, 1'b0, 4'd0, 8'd0, 1'b0);
      step(1'b0, '0, 1'b0, 4'd0, 8'd0, 1'b0);
      idle(2);

      // Identity kernel out of reset.
      out_q.delete();
      for (int i = 0; i < 9; i++) w[i] = 8'h10;
      w[4] = 8'h5A;
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      idle(5);
      check_val("ident_count", out_q.size(), 1);
      if (out_q.size() > 0) check_val("ident_pix", out_q[0], 32'h5A);

      // Box blur with shift 3.
      for (int i = 0; i < 9; i++) cfg(4'(i), 8'd1);
      cfg(4'd9, 8'd3);
      out_q.delete();
      for (int i = 0; i < 9; i++) w[i] = 8'd16;
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      for (int i = 0; i < 9; i++) w[i] = 8'd255;
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      idle(4);
      check_val("box_count", out_q.size(), 2);
      if (out_q.size() > 1) begin
         check_val("box_16", out_q[0], 18);
         check_val("box_255", out_q[1], 255);
      end

      // Sobel Gx, both polarities.
      for (int i = 0; i < 9; i++) cfg(4'(i), 8'(sobel[i]));
      cfg(4'd9, 8'd0);
      out_q.delete();
      w = rand_win();
      for (int r = 0; r < 3; r++) begin w[3*r] = 8'd0;   w[3*r+2] = 8'd255; end
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      for (int r = 0; r < 3; r++) begin w[3*r] = 8'd255; w[3*r+2] = 8'd0;   end
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      idle(4);
      check_val("sobel_count", out_q.size(), 2);
      if (out_q.size() > 1) begin
         check_val("sobel_pos", out_q[0], 255);
`ifdef CONV_ABS_EN
         check_val("sobel_neg", out_q[1], 255);
`else
         check_val("sobel_neg", out_q[1], 0);
`endif
      end

      // Config timing: k[4]=2 written alongside the second of four windows.
      for (int i = 0; i < 9; i++) cfg(4'(i), (i == 4) ? 8'd1 : 8'd0);
      out_q.delete();
      for (int j = 0; j < 4; j++) begin
         w = rand_win();
         w[4] = 8'd100;
         step(1'b1, w, (j == 1), 4'd4, 8'd2, 1'b1);
      end
      idle(4);
      check_val("cfgt_count", out_q.size(), 4);
      if (out_q.size() > 3) begin
         check_val("cfgt_out1", out_q[0], 100);
         check_val("cfgt_out2", out_q[1], 100);
         check_val("cfgt_out3", out_q[2], 200);
         check_val("cfgt_out4", out_q[3], 200);
      end

      // Reset with two windows in flight: both dropped, kernel back to identity.
      out_q.delete();
      w = rand_win(); w[4] = 8'd50;
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      w = rand_win(); w[4] = 8'd60;
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      step(1'b0, '0, 1'b0, 4'd0, 8'd0, 1'b0);
      idle(4);
      check_val("rst_no_valid", out_q.size(), 0);
      w = rand_win(); w[4] = 8'd77;
      step(1'b1, w, 1'b0, 4'd0, 8'd0, 1'b1);
      idle(4);
      check_val("rst_ident_count", out_q.size(), 1);
      if (out_q.size() > 0) check_val("rst_ident_pix", out_q[0], 77);

      // Full row with random gaps, random windows and occasional random config writes.
      step(1'b0, '0, 1'b0, 4'd0, 8'd0, 1'b0);
      out_q.delete();
      out_cnt = 0;
      rd_pulses = 0;
      rd_at = 0;
      sent = 0;
      iters = 0;
      while (sent < MAX_COLS + 1 && iters < 5000) begin
         iters++;
         en = ($urandom_range(0, 3) != 0);
         step(en, rand_win(), ($urandom_range(0, 7) == 0),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
         if (en) sent++;
      end
      idle(4);
      check_val("row_sent", sent, MAX_COLS + 1);
      check_val("row_outputs", out_cnt, MAX_COLS + 1);
      check_val("row_pulses", rd_pulses, 1);
      check_val("row_pulse_at", rd_at, MAX_COLS);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
